// File: rtl/delay_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delay_pkg
// Purpose  : Shared types, option bit positions and saturating add for the
//            delay sequencer.
// Revision : 1.0  initial release
// ============================================================================
package delay_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam int OPT_MIX    = 3;
   localparam int OPT_DLY_HI = 2;
   localparam int OPT_DLY_LO = 0;

   // Widest sample the saturating adder supports; callers sign-extend into it.
   localparam int SAT_MAX_W  = 64;

   function automatic logic signed [SAT_MAX_W-1:0] sat_add(
      input logic signed [SAT_MAX_W-1:0] a,
      input logic signed [SAT_MAX_W-1:0] b,
      input int unsigned                 width
   );
      logic signed [SAT_MAX_W:0] sum;
      logic signed [SAT_MAX_W:0] hi;
      logic signed [SAT_MAX_W:0] lo;
      logic signed [SAT_MAX_W:0] one;
      one = (SAT_MAX_W+1)'(1);
      hi  = (one << (width - 1)) - one;
      lo  = ~hi;
      sum = (SAT_MAX_W+1)'(a) + (SAT_MAX_W+1)'(b);
      if (sum > hi) begin
         return hi[SAT_MAX_W-1:0];
      end else if (sum < lo) begin
         return lo[SAT_MAX_W-1:0];
      end
      return sum[SAT_MAX_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/delay_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_sequencer_if
// Purpose  : Sample stream handshake and delay-RAM port of the sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface delay_sequencer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3
);
   logic                  x_valid;
   logic                  x_ready;
   logic [DATA_WIDTH-1:0] x;
   logic                  y_valid;
   logic [DATA_WIDTH-1:0] y;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  x_valid, x, ram_rdata,
      output x_ready, y_valid, y, ram_addr, ram_we, ram_wdata
   );

   modport master (
      output x_valid, x, ram_rdata,
      input  x_ready, y_valid, y, ram_addr, ram_we, ram_wdata
   );
endinterface
`default_nettype wire

// File: rtl/delay_sequencer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : delay_addr_gen
// Purpose  : Circular-buffer write pointer, fill counter, delay decode and
//            tap address generation.
// Revision : 1.0  initial release
// ============================================================================
module delay_addr_gen #(
   parameter int SIZE       = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic [2:0]            i_dly_code,
   input  logic [ADDR_WIDTH:0]   i_d_lat,
   input  logic                  i_advance,
   output logic [ADDR_WIDTH:0]   o_d_dec,
   output logic [ADDR_WIDTH-1:0] o_wp,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic [ADDR_WIDTH:0]   o_fill
);
   localparam logic [ADDR_WIDTH:0]   c_SIZE    = (ADDR_WIDTH+1)'(SIZE);
   localparam logic [ADDR_WIDTH-1:0] c_WP_LAST = ADDR_WIDTH'(SIZE - 1);

   logic [ADDR_WIDTH-1:0] r_wp;
   logic [ADDR_WIDTH:0]   r_fill;
   logic [ADDR_WIDTH:0]   w_wp_ext;

   // Code 0 selects the full buffer; oversize codes clamp to the buffer depth.
   always_comb begin
      o_d_dec = c_SIZE;
      if ((i_dly_code != 3'd0) && (int'(i_dly_code) < SIZE)) begin
         o_d_dec = (ADDR_WIDTH+1)'(i_dly_code);
      end
   end

   always_comb begin
      w_wp_ext = {1'b0, r_wp};
      if (w_wp_ext >= i_d_lat) begin
         o_rd_addr = ADDR_WIDTH'(w_wp_ext - i_d_lat);
      end else begin
         o_rd_addr = ADDR_WIDTH'(w_wp_ext + c_SIZE - i_d_lat);
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_wp   <= '0;
         r_fill <= '0;
      end else if (i_advance) begin
         r_wp <= (r_wp == c_WP_LAST) ? '0 : r_wp + 1'b1;
         if (r_fill != c_SIZE) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

   assign o_wp   = r_wp;
   assign o_fill = r_fill;

endmodule
`default_nettype wire

// File: rtl/delay_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : delay_sequencer
// Purpose  : Drives a single-port sample RAM as a circular delay line and
//            emits the delayed tap or an echo mix per accepted sample.
// Revision : 1.0  initial release
// ============================================================================
module delay_sequencer
   import delay_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SIZE       = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              en,
   input  logic [3:0]        options,
   delay_sequencer_if.slave  bus
);
   state_t                       r_state;
   logic signed [DATA_WIDTH-1:0] r_x_lat;
   logic                         r_mix_lat;
   logic [ADDR_WIDTH:0]          r_d_lat;
   logic [DATA_WIDTH-1:0]        r_y;
   logic                         r_y_valid;

   logic                         w_x_ready;
   logic                         w_accept;
   logic [ADDR_WIDTH:0]          w_d_dec;
   logic [ADDR_WIDTH-1:0]        w_wp;
   logic [ADDR_WIDTH-1:0]        w_rd_addr;
   logic [ADDR_WIDTH:0]          w_fill;
   logic signed [DATA_WIDTH-1:0] w_tap;

   delay_addr_gen #(
      .SIZE       (SIZE),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .CLK        (CLK),
      .rst        (rst),
      .i_dly_code (options[OPT_DLY_HI:OPT_DLY_LO]),
      .i_d_lat    (r_d_lat),
      .i_advance  (r_state == WRITE),
      .o_d_dec    (w_d_dec),
      .o_wp       (w_wp),
      .o_rd_addr  (w_rd_addr),
      .o_fill     (w_fill)
   );

   assign w_x_ready = (r_state == IDLE) && en && !rst;
   assign w_accept  = bus.x_valid && w_x_ready;

   // Until the buffer holds d_lat samples the RAM word at the tap is stale.
   assign w_tap = (w_fill >= r_d_lat) ? bus.ram_rdata : '0;

   always_comb begin
      bus.ram_addr  = '0;
      bus.ram_we    = 1'b0;
      bus.ram_wdata = '0;
      case (r_state)
         READ: begin
            bus.ram_addr = w_rd_addr;
         end
         WRITE: begin
            bus.ram_addr  = w_wp;
            bus.ram_we    = 1'b1;
            bus.ram_wdata = r_x_lat;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state   <= IDLE;
         r_x_lat   <= '0;
         r_mix_lat <= 1'b0;
         r_d_lat   <= (ADDR_WIDTH+1)'(SIZE);
         r_y       <= '0;
         r_y_valid <= 1'b0;
      end else begin
         r_y_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_x_lat   <= bus.x;
                  r_mix_lat <= options[OPT_MIX];
                  r_d_lat   <= w_d_dec;
                  r_state   <= READ;
               end
            end
            READ: begin
               r_state <= WRITE;
            end
            WRITE: begin
               if (r_mix_lat) begin
                  r_y <= DATA_WIDTH'(sat_add(SAT_MAX_W'(r_x_lat),
                                             SAT_MAX_W'(w_tap >>> 1),
                                             DATA_WIDTH));
               end else begin
                  r_y <= w_tap;
               end
               r_y_valid <= 1'b1;
               r_state   <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.x_ready = w_x_ready;
   assign bus.y       = r_y;
   assign bus.y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_delay_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_sequencer
// Purpose  : Self-checking bench: hand vectors, random stimulus against a
//            sample-history model, reset and enable corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_delay_sequencer;
   localparam int DW   = 32;
   localparam int SIZE = 8;
   localparam int AW   = 3;

   logic       CLK     = 1'b0;
   logic       rst     = 1'b1;
   logic       en      = 1'b1;
   logic [3:0] options = 4'd0;

   delay_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   delay_sequencer #(
      .DATA_WIDTH (DW),
      .SIZE       (SIZE),
      .ADDR_WIDTH (AW)
   ) dut (
      .CLK     (CLK),
      .rst     (rst),
      .en      (en),
      .options (options),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   logic [DW-1:0] mem [SIZE];
   always @(posedge CLK) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   int            n_checks = 0;
   int            n_fail   = 0;
   int            wp_model = 0;
   logic [DW-1:0] hist [$];

   typedef struct {
      bit            rst_before;
      logic [3:0]    opt;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
   } vec_t;
   vec_t vecs [38];
   int   nv = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input bit r, input logic [3:0] o, input logic [DW-1:0] xv, input logic [DW-1:0] yv);
      vecs[nv].rst_before = r;
      vecs[nv].opt        = o;
      vecs[nv].x          = xv;
      vecs[nv].y          = yv;
      nv++;
   endtask

   // Output predicted from the list of samples accepted since reset.
   function automatic logic [DW-1:0] model_y(input logic [3:0] opt, input logic [DW-1:0] xv);
      int     d;
      longint tap, half, s;
      d = (opt[2:0] == 3'd0) ? SIZE : int'(opt[2:0]);
      if (d > SIZE) d = SIZE;
      tap = 0;
      if (hist.size() >= d) tap = longint'(signed'(hist[hist.size() - d]));
      if (!opt[3]) return tap[DW-1:0];
      half = tap / 2;
      if (tap < 0 && (tap % 2) != 0) half = half - 1;
      s = longint'(signed'(xv)) + half;
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      return s[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] rand_x();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   task automatic do_reset(input bit check_vals);
      rst = 1'b1;
      bus.x_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      if (check_vals) begin
         check("rst_x_ready", 64'(bus.x_ready), 64'd0);
         check("rst_y_valid", 64'(bus.y_valid), 64'd0);
         check("rst_y", 64'(bus.y), 64'd0);
         check("rst_ram_we", 64'(bus.ram_we), 64'd0);
         check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
         check("rst_ram_wdata", 64'(bus.ram_wdata), 64'd0);
      end
      rst = 1'b0;
      @(negedge CLK);
      check("post_rst_ready", 64'(bus.x_ready), 64'(en));
      hist.delete();
      wp_model = 0;
   endtask

   task automatic send(input logic [3:0] opt, input logic [DW-1:0] xv, input bit drop_en,
                       output logic [DW-1:0] yv);
      int t;
      t = 0;
      while (!bus.x_ready && t < 20) begin
         @(negedge CLK);
         t++;
      end
      check("ready_wait", 64'(bus.x_ready), 64'd1);
      options     = opt;
      bus.x       = xv;
      bus.x_valid = 1'b1;
      @(negedge CLK);
      bus.x_valid = 1'b0;
      bus.x       = $urandom;
      options     = 4'($urandom_range(0, 15));
      check("read_ready", 64'(bus.x_ready), 64'd0);
      check("read_we", 64'(bus.ram_we), 64'd0);
      check("read_yv", 64'(bus.y_valid), 64'd0);
      @(negedge CLK);
      check("write_we", 64'(bus.ram_we), 64'd1);
      check("write_addr", 64'(bus.ram_addr), 64'(wp_model));
      check("write_data", 64'(bus.ram_wdata), 64'(xv));
      check("write_yv", 64'(bus.y_valid), 64'd0);
      if (drop_en) en = 1'b0;
      @(negedge CLK);
      check("y_valid", 64'(bus.y_valid), 64'd1);
      check("ready_at_y", 64'(bus.x_ready), 64'(en));
      yv       = bus.y;
      wp_model = (wp_model + 1) % SIZE;
      hist.push_back(xv);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] yv, ye;
      bus.x_valid = 1'b0;
      bus.x       = '0;

      for (int i = 1; i <= 10; i++)
         add_vec(i == 1, 4'b0011, 32'(i), (i <= 3) ? 32'd0 : 32'(i - 3));
      add_vec(1'b1, 4'b1010, 32'd100, 32'd100);
      add_vec(1'b0, 4'b1010, 32'd200, 32'd200);
      add_vec(1'b0, 4'b1010, 32'd300, 32'd350);
      add_vec(1'b0, 4'b1010, 32'd400, 32'd500);
      add_vec(1'b1, 4'b1001, 32'h0000_0040, 32'h0000_0040);
      add_vec(1'b0, 4'b1001, 32'h7FFF_FFF0, 32'h7FFF_FFFF);
      add_vec(1'b0, 4'b1001, 32'hFFFF_FFC0, 32'h3FFF_FFB8);
      add_vec(1'b0, 4'b1001, 32'h8000_0000, 32'h8000_0000);
      for (int i = 1; i <= 20; i++)
         add_vec(i == 1, 4'b0000, 32'(i), (i <= 8) ? 32'd0 : 32'(i - 8));

      do_reset(1'b1);
      // Leave random junk in every RAM word so unfilled taps are exposed.
      for (int i = 0; i < SIZE; i++) send(4'b0000, $urandom, 1'b0, yv);

      for (int i = 0; i < nv; i++) begin
         if (vecs[i].rst_before) do_reset(1'b1);
         send(vecs[i].opt, vecs[i].x, 1'b0, yv);
         check($sformatf("vec%0d_y", i), 64'(yv), 64'(vecs[i].y));
      end

      do_reset(1'b0);
      for (int i = 0; i < 30; i++) begin
         logic [3:0]    o;
         logic [DW-1:0] xv;
         o  = 4'($urandom_range(0, 15));
         xv = rand_x();
         ye = model_y(o, xv);
         send(o, xv, 1'b0, yv);
         check($sformatf("rand%0d_y", i), 64'(yv), 64'(ye));
      end

      ye = model_y(4'b0101, 32'd77);
      send(4'b0101, 32'd77, 1'b1, yv);
      check("en_drop_y", 64'(yv), 64'(ye));
      for (int i = 0; i < 10; i++) begin
         bus.x_valid = 1'b1;
         bus.x       = $urandom;
         @(negedge CLK);
         check("en_off_ready", 64'(bus.x_ready), 64'd0);
         check("en_off_yv", 64'(bus.y_valid), 64'd0);
         check("en_off_we", 64'(bus.ram_we), 64'd0);
      end
      bus.x_valid = 1'b0;
      en          = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 30; i++) begin
         logic [3:0]    o;
         logic [DW-1:0] xv;
         o  = 4'($urandom_range(0, 15));
         xv = rand_x();
         ye = model_y(o, xv);
         send(o, xv, 1'b0, yv);
         check($sformatf("resume%0d_y", i), 64'(yv), 64'(ye));
      end

      send(4'b0001, 32'd11, 1'b0, yv);
      send(4'b0001, 32'd12, 1'b0, yv);
      options     = 4'b0001;
      bus.x       = 32'd99;
      bus.x_valid = 1'b1;
      @(negedge CLK);
      bus.x_valid = 1'b0;
      check("abort_read_we", 64'(bus.ram_we), 64'd0);
      rst = 1'b1;
      @(negedge CLK);
      check("abort_x_ready", 64'(bus.x_ready), 64'd0);
      check("abort_y_valid", 64'(bus.y_valid), 64'd0);
      check("abort_y", 64'(bus.y), 64'd0);
      check("abort_ram_we", 64'(bus.ram_we), 64'd0);
      check("abort_ram_addr", 64'(bus.ram_addr), 64'd0);
      check("abort_ram_wdata", 64'(bus.ram_wdata), 64'd0);
      rst = 1'b0;
      @(negedge CLK);
      hist.delete();
      wp_model = 0;
      send(4'b0001, 32'd55, 1'b0, yv);
      check("post_abort_y", 64'(yv), 64'd0);
      send(4'b0001, 32'd56, 1'b0, yv);
      check("post_abort_y2", 64'(yv), 64'd55);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
